debounce_scan_ctrl: RTL and testbench
=====================================

Name: debounce_scan_ctrl

Overview:
Multi-channel debounce scheduler. It time-shares one sample prescaler and one compare/count datapath across N_CH raw push-button/switch inputs, scanning the channels round-robin on each sample tick. Channels whose debounced level changes raise pending events. A round-robin arbiter serialises those events onto a single valid/ack event port for the downstream control logic.

Parameters:
N_CH, 4, number of raw input channels (2..16)
TICK_DIV, 50, clocks per sample tick; must be > N_CH+1
STABLE_CNT, 8, consecutive disagreeing samples required to accept a new level (2..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = prescaler runs; 0 = prescaler held at 0, no new scans
raw  input  N_CH  undebounced inputs, asynchronous to clock
clean  output  N_CH  debounced levels
busy  output  1  high while a scan pass is in progress
event_valid  output  1  event presented
event_chan  output  clog2(N_CH)  channel of the presented event
event_rise  output  1  1 = clean went 0->1, 0 = clean went 1->0
event_ack  input  1  consumer accepts the event

Behaviour:
- Reset, asynchronous while low: sync flops 0, clean 0, counters 0, prescaler 0, FSM IDLE, busy 0, pend 0, event_valid/event_chan/event_rise 0, RR pointer at channel 0. All outputs are 0 immediately, including mid-scan.
- raw passes through a 2-flop synchroniser per channel (sync).
- Prescaler counts 0..TICK_DIV-1 while enable=1. tick is a 1-cycle strobe at count TICK_DIV-1, after which the count wraps to 0. With enable=0 the count clears to 0 and no tick occurs.
- FSM has two states:
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: process channel idx each clock. idx==N_CH-1 returns to IDLE; otherwise idx+1.
  - busy = (state==SCAN), so a pass lasts exactly N_CH cycles.
  - A tick during SCAN is ignored.
  - enable falling mid-pass does not abort the pass.
- Per-channel step, for s=sync[idx]:
  - s==clean[idx]: cnt[idx]<=0.
  - s!=clean[idx] and cnt==STABLE_CNT-1: clean[idx]<=s, cnt<=0, pend[idx]<=1, pend_rise[idx]<=s.
  - Otherwise: cnt++.
  - Result: a new level is accepted after STABLE_CNT consecutive disagreeing samples. Any agreeing sample restarts the count.
- Latency from a stable raw edge to clean = 2 clocks + wait to next tick (<=TICK_DIV) + (STABLE_CNT-1)*TICK_DIV + idx + 1 clocks.
- Counter width is clog2(STABLE_CNT) and the counter never exceeds STABLE_CNT-1.
- Event arbiter:
  - When event_valid=0 and any pend is set, select the first pending channel searching from ptr, ptr+1, ... wrapping mod N_CH.
  - Next clock: event_valid=1, event_chan=g, event_rise=pend_rise[g], pend[g]<=0, ptr<=(g+1) mod N_CH.
  - event_valid and its payload hold stable until a clock with event_valid&&event_ack; on that clock event_valid<=0.
  - New selection only happens while event_valid=0, so there is at least 1 idle cycle between events.
  - event_ack while event_valid=0 is ignored.
- Scan setting pend[g] on the same clock the arbiter clears pend[g]: the set wins; pend stays 1 with the new pend_rise.
- New level accepted on a channel whose pend is already 1: pend_rise is overwritten with the newest direction, so the previous unreported edge is lost.

Optional Feature:
EVENT_OVF_EN: when defined, adds output event_ovf[N_CH] and input ovf_clr (1 bit).
- event_ovf[i] is set when channel i accepts a new level while pend[i]=1. It is sticky.
- A 1-cycle ovf_clr pulse clears all bits.
- Reset clears all bits.
- If the set and ovf_clr occur on the same clock, the set wins.
When the macro is undefined, neither port exists and overwrites are silent.

Test Plan:
Bench settings: N_CH=4, TICK_DIV=50, STABLE_CNT=8, 200 ns clock period.
- Reset: hold reset=0 for 300 ns, then release with enable=1 -> all outputs 0 during reset; first busy pulse starts 50 clocks after release and lasts exactly 4 clocks, repeating every 50 clocks.
- Clean press: raw[0] 0->1 held steady -> clean[0]=1 within 2+50+7*50+1 clocks; event_valid=1, event_chan=0, event_rise=1, held until event_ack=1 for one clock, then event_valid=0.
- Bounce rejection: raw[1] toggles high for 5 ticks, low for 1 tick, repeated 10 times -> clean[1] stays 0; no event for channel 1.
- Arbitration: raw[1], raw[2] and raw[3] rise on the same clock, with ptr at 1 after a prior channel-0 event and event_ack tied high -> events chan 1, 2, 3 in order, each event_rise=1, with a 1-cycle gap between valid pulses.
- Overwrite: with event_ack=0, channel 0 rises (event presented), then falls (pend), then rises again -> after ack the next event is chan 0 with event_rise=1; with EVENT_OVF_EN, event_ovf[0]=1 until ovf_clr is pulsed.
- Async reset mid-scan: drive reset=0 while busy=1 and event_valid=1 -> busy, event_valid and clean go to 0 before the next clock edge; normal scanning resumes after release.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debounce scheduler: one prescaler and one scan datapath shared across N_CH inputs,
// with a round-robin valid/ack event port. Define EVENT_OVF_EN to add sticky overwrite flags.
`timescale 1ns/1ps
module debounce_scan_ctrl #(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 50,
  parameter int STABLE_CNT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_CH-1:0]         raw,
  output logic [N_CH-1:0]         clean,
  output logic                    busy,
  output logic                    event_valid,
  output logic [$clog2(N_CH)-1:0] event_chan,
  output logic                    event_rise,
  input  logic                    event_ack
`ifdef EVENT_OVF_EN
  ,
  output logic [N_CH-1:0]         event_ovf,
  input  logic                    ovf_clr
`endif
);

  localparam int IW = $clog2(N_CH);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_CNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CNT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [0:0]      state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] pend_rise;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   gnt;
  logic            gnt_ok;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync    <= '0;
    end else begin
      sync_q1 <= raw;
      sync    <= sync_q1;
    end
  end

  assign tick = enable && (pre == PRE_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (!enable || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // A pass visits every channel once; ticks arriving mid-pass are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else if (state == IDLE) begin
      if (tick) begin
        state <= SCAN;
        idx   <= '0;
      end
    end else if (idx == LAST_IDX) begin
      state <= IDLE;
    end else begin
      idx <= idx + IW'(1);
    end
  end

  assign busy = (state == SCAN);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt_ok = 1'b0;
    gnt    = '0;
    cand   = '0;
    // Walk from the farthest candidate back to ptr so the nearest pending channel wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N_CH);
      if (pend[cand]) begin
        gnt_ok = 1'b1;
        gnt    = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clean       <= '0;
      pend        <= '0;
      pend_rise   <= '0;
      // NOTE: the counter file is reset because a stale count would shorten the first debounce.
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      event_valid <= 1'b0;
      event_chan  <= '0;
      event_rise  <= 1'b0;
      ptr         <= '0;
`ifdef EVENT_OVF_EN
      event_ovf   <= '0;
`endif
    end else begin
      if (event_valid) begin
        if (event_ack) event_valid <= 1'b0;
      end else if (gnt_ok) begin
        event_valid <= 1'b1;
        event_chan  <= gnt;
        event_rise  <= pend_rise[gnt];
        pend[gnt]   <= 1'b0;
        ptr         <= (gnt == LAST_IDX) ? '0 : gnt + IW'(1);
      end
`ifdef EVENT_OVF_EN
      if (ovf_clr) event_ovf <= '0;
`endif
      // Scan updates come last so a fresh acceptance overrides the arbiter's clear.
      if (state == SCAN) begin
        if (sync[idx] == clean[idx]) begin
          cnt[idx] <= '0;
        end else if (cnt[idx] == CNT_MAX) begin
          clean[idx]     <= sync[idx];
          cnt[idx]       <= '0;
          pend[idx]      <= 1'b1;
          pend_rise[idx] <= sync[idx];
`ifdef EVENT_OVF_EN
          if (pend[idx]) event_ovf[idx] <= 1'b1;
`endif
        end else begin
          cnt[idx] <= cnt[idx] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_debounce_scan_ctrl;

  localparam int N  = 4;
  localparam int TD = 50;
  localparam int SC = 8;
  localparam int IW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  raw;
  logic [N-1:0]  clean;
  logic          busy;
  logic          event_valid;
  logic [IW-1:0] event_chan;
  logic          event_rise;
  logic          event_ack;
`ifdef EVENT_OVF_EN
  logic [N-1:0]  event_ovf;
  logic          ovf_clr;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  debounce_scan_ctrl #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .raw         (raw),
    .clean       (clean),
    .busy        (busy),
    .event_valid (event_valid),
    .event_chan  (event_chan),
    .event_rise  (event_rise),
    .event_ack   (event_ack)
`ifdef EVENT_OVF_EN
    ,
    .event_ovf   (event_ovf),
    .ovf_clr     (ovf_clr)
`endif
  );

  always #100 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]  m_d1, m_d2, m_clean, m_pend, m_prise, m_pend_old;
  int            m_run [N];
  int            m_pre, m_pos, m_ptr, m_gnt;
  logic          m_ev_valid, m_ev_rise, m_s, m_tick;
  logic [IW-1:0] m_ev_chan, mc, mp;
`ifdef EVENT_OVF_EN
  logic [N-1:0]  m_ovf;
`endif

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_d1 = '0; m_d2 = '0; m_clean = '0; m_pend = '0; m_prise = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_pre = 0; m_pos = -1; m_ptr = 0;
      m_ev_valid = 1'b0; m_ev_chan = '0; m_ev_rise = 1'b0;
`ifdef EVENT_OVF_EN
      m_ovf = '0;
`endif
    end else begin
      m_pend_old = m_pend;
      if (m_ev_valid) begin
        if (event_ack) m_ev_valid = 1'b0;
      end else begin
        m_gnt = -1;
        for (int k = 0; k < N; k++) begin
          mc = IW'((m_ptr + k) % N);
          if (m_gnt < 0 && m_pend[mc]) m_gnt = int'(mc);
        end
        if (m_gnt >= 0) begin
          mc = IW'(m_gnt);
          m_ev_valid = 1'b1;
          m_ev_chan  = mc;
          m_ev_rise  = m_prise[mc];
          m_pend[mc] = 1'b0;
          m_ptr      = (m_gnt + 1) % N;
        end
      end
`ifdef EVENT_OVF_EN
      if (ovf_clr) m_ovf = '0;
`endif
      if (m_pos >= 0) begin
        mp  = IW'(m_pos);
        m_s = m_d2[mp];
        if (m_s != m_clean[mp]) begin
          m_run[mp] = m_run[mp] + 1;
          if (m_run[mp] == SC) begin
            m_run[mp]   = 0;
            m_clean[mp] = m_s;
`ifdef EVENT_OVF_EN
            if (m_pend_old[mp]) m_ovf[mp] = 1'b1;
`endif
            m_pend[mp]  = 1'b1;
            m_prise[mp] = m_s;
          end
        end else begin
          m_run[mp] = 0;
        end
      end
      m_tick = enable && (m_pre == TD - 1);
      if (m_pos >= 0) m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
      else if (m_tick) m_pos = 0;
      m_pre = (m_tick || !enable) ? 0 : m_pre + 1;
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end

  // ---------------- compare + event monitor ----------------
  int   cyc = 0;
  bit   prev_valid = 1'b0;
  int   ev_chan_q[$];
  int   ev_rise_q[$];
  int   ev_cyc_q[$];
  int   ev_count [N];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_clean", 32'(clean), 32'(m_clean));
      check("model_busy", 32'(busy), 32'(m_pos >= 0));
      check("model_event_valid", 32'(event_valid), 32'(m_ev_valid));
      if (m_ev_valid) begin
        check("model_event_chan", 32'(event_chan), 32'(m_ev_chan));
        check("model_event_rise", 32'(event_rise), 32'(m_ev_rise));
      end
`ifdef EVENT_OVF_EN
      check("model_event_ovf", 32'(event_ovf), 32'(m_ovf));
`endif
    end
    if (event_valid && !prev_valid) begin
      ev_chan_q.push_back(int'(event_chan));
      ev_rise_q.push_back(int'(event_rise));
      ev_cyc_q.push_back(cyc);
      ev_count[event_chan] = ev_count[event_chan] + 1;
    end
    prev_valid = event_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_clean(input int ch, input logic val, input int budget,
                            input string name, output int n);
    logic [IW-1:0] c;
    c = IW'(ch);
    n = 0;
    while (clean[c] !== val && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(clean[c] === val), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (event_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(event_valid === 1'b1), 32'd1);
  endtask

  task automatic set_raw(input int ch, input logic val);
    logic [IW-1:0] c;
    c = IW'(ch);
    raw[c] = val;
  endtask

  initial begin
    #(200 * 60000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int n, len, gap, ch1_before;
  int tgt [N];
  int cur [N];
  int bl [N];
  int en_hold;
  logic [N-1:0] rv;

  initial begin
    reset = 1'b1; enable = 1'b0; raw = '0; event_ack = 1'b0;
    for (int i = 0; i < N; i++) ev_count[i] = 0;
`ifdef EVENT_OVF_EN
    ovf_clr = 1'b0;
`endif
    #10;
    reset = 1'b0;
    chk_en = 1'b1;
    #300;

    // Reset: all outputs zero while held.
    @(negedge clock);
    check("reset_clean", 32'(clean), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_event_valid", 32'(event_valid), 32'd0);
    check("reset_event_chan", 32'(event_chan), 32'd0);
    check("reset_event_rise", 32'(event_rise), 32'd0);
    #1;
    enable = 1'b1;
    reset  = 1'b1;

    // First scan pass: starts 50 clocks after release, lasts 4, repeats every 50.
    n = 0;
    do begin @(negedge clock); n++; end while (!busy && n < 200);
    check("first_busy_delay", 32'(n), 32'd50);
    len = 0;
    while (busy && len < 20) begin len++; @(negedge clock); end
    check("busy_length", 32'(len), 32'd4);
    gap = len;
    do begin @(negedge clock); gap++; end while (!busy && gap < 200);
    check("busy_period", 32'(gap), 32'd50);
    #1;

    // Clean press on channel 0.
    set_raw(0, 1'b1);
    wait_clean(0, 1'b1, 500, "press_clean_reached", n);
    check("press_latency_max", 32'(n <= 403), 32'd1);
    check("press_latency_min", 32'(n >= 353), 32'd1);
    step();
    check("press_event_valid", 32'(event_valid), 32'd1);
    check("press_event_chan", 32'(event_chan), 32'd0);
    check("press_event_rise", 32'(event_rise), 32'd1);
    repeat (5) step();
    check("press_event_held", 32'(event_valid), 32'd1);
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    check("press_event_acked", 32'(event_valid), 32'd0);

    // Bounce rejection on channel 1.
    ch1_before = ev_count[1];
    for (int r = 0; r < 10; r++) begin
      set_raw(1, 1'b1);
      repeat (5 * TD) step();
      set_raw(1, 1'b0);
      repeat (TD) step();
    end
    check("bounce_clean1", 32'(clean[1]), 32'd0);
    check("bounce_no_ch1_event", 32'(ev_count[1] - ch1_before), 32'd0);

    // Arbitration: three channels rise together between passes, ack tied high.
    event_ack = 1'b1;
    n = 0;
    while (!busy && n < 60) begin step(); n++; end
    n = 0;
    while (busy && n < 10) begin step(); n++; end
    ev_chan_q.delete(); ev_rise_q.delete(); ev_cyc_q.delete();
    raw[3:1] = 3'b111;
    n = 0;
    while (ev_chan_q.size() < 3 && n < 600) begin step(); n++; end
    check("arb_event_count", 32'(ev_chan_q.size()), 32'd3);
    if (ev_chan_q.size() >= 3) begin
      check("arb_chan0", 32'(ev_chan_q[0]), 32'd1);
      check("arb_chan1", 32'(ev_chan_q[1]), 32'd2);
      check("arb_chan2", 32'(ev_chan_q[2]), 32'd3);
      check("arb_rise_all", 32'(ev_rise_q[0] + ev_rise_q[1] + ev_rise_q[2]), 32'd3);
      check("arb_spacing01", 32'(ev_cyc_q[1] - ev_cyc_q[0]), 32'd2);
      check("arb_spacing12", 32'(ev_cyc_q[2] - ev_cyc_q[1]), 32'd2);
    end

    // Overwrite: release ch0 (consumed), then rise/fall/rise with the event unacknowledged.
    set_raw(0, 1'b0);
    wait_clean(0, 1'b0, 600, "ovw_release_reached", n);
    repeat (4) step();
    event_ack = 1'b0;
    set_raw(0, 1'b1);
    wait_clean(0, 1'b1, 600, "ovw_rise1_reached", n);
    wait_valid(5, "ovw_event_presented");
    check("ovw_first_chan", 32'(event_chan), 32'd0);
    check("ovw_first_rise", 32'(event_rise), 32'd1);
    set_raw(0, 1'b0);
    wait_clean(0, 1'b0, 600, "ovw_fall_reached", n);
    check("ovw_still_held", 32'(event_valid), 32'd1);
    set_raw(0, 1'b1);
    wait_clean(0, 1'b1, 600, "ovw_rise2_reached", n);
`ifdef EVENT_OVF_EN
    step();
    check("ovw_ovf_set", 32'(event_ovf[0]), 32'd1);
`endif
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    check("ovw_ack_drop", 32'(event_valid), 32'd0);
    step();
    check("ovw_next_valid", 32'(event_valid), 32'd1);
    check("ovw_next_chan", 32'(event_chan), 32'd0);
    check("ovw_next_rise", 32'(event_rise), 32'd1);
`ifdef EVENT_OVF_EN
    check("ovw_ovf_sticky", 32'(event_ovf[0]), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovw_ovf_cleared", 32'(event_ovf[0]), 32'd0);
`endif
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;

    // Async reset mid-scan with an event presented.
    set_raw(2, 1'b0);
    wait_valid(600, "areset_event_presented");
    check("areset_event_chan", 32'(event_chan), 32'd2);
    check("areset_event_rise", 32'(event_rise), 32'd0);
    n = 0;
    while (!busy && n < 60) begin step(); n++; end
    check("areset_busy_before", 32'(busy && event_valid), 32'd1);
    #49;
    reset = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_event_valid", 32'(event_valid), 32'd0);
    check("areset_clean", 32'(clean), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    n = 0;
    while (!busy && n < 60) begin step(); n++; end
    check("areset_scan_resumes", 32'(busy), 32'd1);
    check("areset_resume_delay", 32'(n), 32'd50);

    // Randomized phase.
    for (int i = 0; i < N; i++) begin
      cur[i] = int'((raw >> i) & N'(1));
      tgt[i] = cur[i];
      bl[i]  = 0;
    end
    en_hold = 0;
    for (int t = 0; t < 15000; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1499) == 0) begin
          tgt[i] = 1 - tgt[i];
          bl[i]  = $urandom_range(0, 300);
        end
        if (bl[i] > 0) begin
          bl[i]--;
          if ($urandom_range(0, 19) == 0) cur[i] = 1 - cur[i];
        end else begin
          cur[i] = tgt[i];
        end
      end
      rv = '0;
      for (int i = 0; i < N; i++) if (cur[i] != 0) rv = rv | (N'(1) << i);
      raw = rv;
      if (en_hold > 0) begin
        en_hold--;
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 2999) == 0) en_hold = $urandom_range(1, 200);
      end
      event_ack = ($urandom_range(0, 3) == 0);
`ifdef EVENT_OVF_EN
      ovf_clr = ($urandom_range(0, 499) == 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
